// File: rtl/sim_ram_responder.sv
// Simulation RAM responder: word-addressed 32-bit memory behind a readReq/writeReq handshake with LATENCY-cycle read return.
// Optional macro SIM_RAM_BOUNDS_CHECK_EN flags out-of-range addresses on err instead of aliasing them.
module sim_ram_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readReq,
  input  logic        writeReq,
  input  logic [31:0] ramAddress,
  input  logic [31:0] ramOut,
  output logic [31:0] ramIn,
  output logic        ramValid,
  output logic        busy,
  output logic        err,
  output logic [15:0] readCount,
  output logic [15:0] writeCount
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [31:0] OOB_DATA  = 32'hDEADBEEF;
  localparam logic [3:0]  WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                state, state_d;
  logic [3:0]            wait_cnt, wait_cnt_d;
  logic [DEPTH_LOG2-1:0] idx, addr_q;
  logic                  rd_q, oob_q, oob_now;
  logic                  accept, load;
  logic [31:0]           load_data;
  logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];

  assign idx    = ramAddress[DEPTH_LOG2-1:0];
  assign accept = (state == IDLE) && (readReq || writeReq);
  assign busy   = (state != IDLE);

`ifdef SIM_RAM_BOUNDS_CHECK_EN
  assign oob_now = |ramAddress[31:DEPTH_LOG2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err <= 1'b0;
    else if (accept && oob_now)
      err <= 1'b1;
  end
`else
  logic unused_upper_addr;
  assign unused_upper_addr = |ramAddress[31:DEPTH_LOG2];
  assign oob_now = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    load       = 1'b0;
    load_data  = oob_q ? OOB_DATA : mem[addr_q];
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d   = RESP;
            load      = readReq;
            // Same-edge write is forwarded so a combined request returns the new data
            load_data = oob_now ? OOB_DATA : (writeReq ? ramOut : mem[idx]);
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_d = RESP;
          load    = rd_q;
        end else begin
          wait_cnt_d = wait_cnt - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      rd_q       <= 1'b0;
      oob_q      <= 1'b0;
      ramIn      <= 32'd0;
      ramValid   <= 1'b0;
      readCount  <= 16'd0;
      writeCount <= 16'd0;
    end else begin
      ramValid <= load;
      if (load)
        ramIn <= load_data;
      if (accept) begin
        addr_q <= idx;
        rd_q   <= readReq;
        oob_q  <= oob_now;
        if (readReq)
          readCount <= readCount + 16'd1;
        if (writeReq)
          writeCount <= writeCount + 16'd1;
      end
    end
  end

  // Contents survive reset; only the write enable is held off while reset is high
  always_ff @(posedge clk) begin
    if (!reset && accept && writeReq && !oob_now)
      mem[idx] <= ramOut;
  end

endmodule

// File: tb/tb_sim_ram_responder.sv
// Scoreboard bench: LATENCY=1 and LATENCY=4 responders share one stimulus stream; read results checked for data and arrival cycle.
module tb_sim_ram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        readReq = 1'b0, writeReq = 1'b0;
  logic [31:0] ramAddress = 32'd0, ramOut = 32'd0;

  logic [31:0] ramIn1, ramIn4;
  logic        ramValid1, ramValid4, busy1, busy4, err1, err4;
  logic [15:0] rc1, wc1, rc4, wc4;

  sim_ram_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .readReq(readReq), .writeReq(writeReq),
    .ramAddress(ramAddress), .ramOut(ramOut), .ramIn(ramIn1), .ramValid(ramValid1),
    .busy(busy1), .err(err1), .readCount(rc1), .writeCount(wc1));

  sim_ram_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .readReq(readReq), .writeReq(writeReq),
    .ramAddress(ramAddress), .ramOut(ramOut), .ramIn(ramIn4), .ramValid(ramValid4),
    .busy(busy4), .err(err4), .readCount(rc4), .writeCount(wc4));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t        q1[$], q4[$];
  logic [31:0] mdl [0:1023];
  logic [15:0] rcnt = 16'd0, wcnt = 16'd0;
  logic        exp_err = 1'b0;
  int          cyc = 0;
  int          n_checks = 0, n_errors = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ramValid1) begin
      if (q1.size() == 0) check("l1_spurious_valid", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("l1_rdata", ramIn1, e.d);
        check("l1_arrival_cycle", 32'(cyc), 32'(e.c));
      end
    end
    if (ramValid4) begin
      if (q4.size() == 0) check("l4_spurious_valid", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        check("l4_rdata", ramIn4, e.d);
        check("l4_arrival_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic check_zero(input string p);
    check({p, "_ramIn1"}, ramIn1, 32'd0);
    check({p, "_ramIn4"}, ramIn4, 32'd0);
    check({p, "_valid1"}, 32'(ramValid1), 32'd0);
    check({p, "_valid4"}, 32'(ramValid4), 32'd0);
    check({p, "_busy1"}, 32'(busy1), 32'd0);
    check({p, "_busy4"}, 32'(busy4), 32'd0);
    check({p, "_err1"}, 32'(err1), 32'd0);
    check({p, "_err4"}, 32'(err4), 32'd0);
    check({p, "_rc1"}, 32'(rc1), 32'd0);
    check({p, "_wc1"}, 32'(wc1), 32'd0);
    check({p, "_rc4"}, 32'(rc4), 32'd0);
    check({p, "_wc4"}, 32'(wc4), 32'd0);
  endtask

  // Drives a request at a negedge; the following posedge is the accepting edge.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input bit push4);
    logic        oob;
    logic [31:0] e;
    @(negedge clk);
    readReq = rd; writeReq = wr; ramAddress = addr; ramOut = data;
`ifdef SIM_RAM_BOUNDS_CHECK_EN
    oob = (addr[31:10] != 22'd0);
`else
    oob = 1'b0;
`endif
    if (wr && !oob) mdl[addr[9:0]] = data;
    e = oob ? 32'hDEADBEEF : mdl[addr[9:0]];
    if (oob) exp_err = 1'b1;
    if (rd) rcnt++;
    if (wr) wcnt++;
    if (rd) begin
      q1.push_back('{e, cyc + 1});
      if (push4) q4.push_back('{e, cyc + 4});
    end
  endtask

  // Waits for both responders to go idle; with hold, the request stays up one more cycle with altered data.
  task automatic finish_req(input bit hold);
    int n1 = 0, n4 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0 && hold) ramOut = ~ramOut;
      else begin readReq = 1'b0; writeReq = 1'b0; end
      if (busy1) n1++;
      if (busy4) n4++;
      if (!busy1 && !busy4) break;
    end
    check("l1_busy_cycles", 32'(n1), 32'd1);
    check("l4_busy_cycles", 32'(n4), 32'd4);
    check("l1_readCount", 32'(rc1), 32'(rcnt));
    check("l1_writeCount", 32'(wc1), 32'(wcnt));
    check("l4_readCount", 32'(rc4), 32'(rcnt));
    check("l4_writeCount", 32'(wc4), 32'(wcnt));
    check("l1_err", 32'(err1), 32'(exp_err));
    check("l4_err", 32'(err4), 32'(exp_err));
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input bit hold);
    drive(rd, wr, addr, data, 1'b1);
    finish_req(hold);
  endtask

  initial begin
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    req(1'b0, 1'b1, 32'd5, 32'h7777F00D, 1'b0);
    req(1'b1, 1'b0, 32'd5, 32'h0, 1'b0);
    req(1'b0, 1'b1, 32'd2, 32'h12345678, 1'b0);
    req(1'b1, 1'b0, 32'd2, 32'h0, 1'b0);
    req(1'b1, 1'b1, 32'd9, 32'hCAFEBABE, 1'b0);
    // Second cycle of a held request lands while busy and must be dropped
    req(1'b1, 1'b1, 32'd5, 32'h0BADF00D, 1'b1);
    req(1'b1, 1'b0, 32'd5, 32'h0, 1'b0);

    req(1'b0, 1'b1, 32'd0, 32'hA5A5A5A5, 1'b0);
    req(1'b0, 1'b1, 32'h400, 32'h1, 1'b0);
    req(1'b1, 1'b0, 32'd0, 32'h0, 1'b0);
    req(1'b1, 1'b0, 32'h400, 32'h0, 1'b0);

    for (int a = 16; a < 24; a++) req(1'b0, 1'b1, 32'(a), $urandom, 1'b0);
    for (int k = 0; k < 10; k++) begin
      logic rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      req(rd, wr, 32'($urandom_range(16, 23)), $urandom, 1'b0);
    end

    // Reset one edge after accepting a write+read to addr 3: LATENCY=4 read is abandoned
    drive(1'b1, 1'b1, 32'd3, 32'h3C3C3C3C, 1'b0);
    @(posedge clk);
    #1 readReq = 1'b0; writeReq = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_zero("midreset");
    rcnt = 16'd0; wcnt = 16'd0; exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    req(1'b1, 1'b0, 32'd3, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    check("l1_pending_reads", 32'(q1.size()), 32'd0);
    check("l4_pending_reads", 32'(q4.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sim_ram_responder.md
SIM_RAM_RESPONDER -- requirements
Module: sim_ram_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 1, legal range 1..15, meaning number of accept-to-data clock edges.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port readReq  input  1  read request from requestor.
REQ-006 SHALL have port writeReq  input  1  write request from requestor.
REQ-007 SHALL have port ramAddress  input  32  word address of request.
REQ-008 SHALL have port ramOut  input  32  write data from requestor.
REQ-009 SHALL have port ramIn  output  32  registered read data to requestor.
REQ-010 SHALL have port ramValid  output  1  one-cycle pulse, ramIn holds completed read data.
REQ-011 SHALL have port busy  output  1  high while a request is in flight; new requests ignored.
REQ-012 SHALL have port err  output  1  sticky out-of-range flag (see Configuration).
REQ-013 SHALL have ports readCount and writeCount  output  16 each  accepted-request counters.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; busy = (state != IDLE).
REQ-015 In IDLE, a posedge with readReq or writeReq high SHALL be the accepting edge A; address and data captured at A.
REQ-016 Writes SHALL commit to memory at A; a write-only request still passes through RESP, with ramValid low and ramIn unchanged.
REQ-017 readReq and writeReq both high at A: write SHALL commit first, read SHALL return the newly written data; both counters increment.
REQ-018 Read data SHALL be loaded onto ramIn at edge A+LATENCY-1 (LATENCY=1: at A itself); ramValid SHALL be high for exactly the following cycle.
REQ-019 Transitions: IDLE->RESP at A when LATENCY=1; IDLE->WAIT at A otherwise; WAIT counts down, ->RESP at A+LATENCY-1; RESP->IDLE unconditionally after one cycle.
REQ-020 Requests present while not in IDLE SHALL be ignored entirely: no capture, no memory change, no count.
REQ-021 ramIn SHALL hold its last value outside completion edges.
REQ-022 readCount/writeCount SHALL increment by 1 at A and wrap 16'hFFFF -> 0.
REQ-023 Memory index SHALL be ramAddress[DEPTH_LOG2-1:0]; ramAddress is a word address (requestor divides byte pointer by 4).

Reset
REQ-024 Asserting reset SHALL immediately force state IDLE, ramIn=0, ramValid=0, busy=0, err=0, readCount=0, writeCount=0.
REQ-025 Memory contents SHALL NOT be cleared by reset; a write committed at A before a mid-operation reset SHALL remain.
REQ-026 A read in flight at reset SHALL be abandoned; no ramValid pulse after reset deasserts.

Configuration
REQ-027 Macro SIM_RAM_BOUNDS_CHECK_EN defined: a request with ramAddress[31:DEPTH_LOG2] != 0 SHALL set err (sticky until reset), suppress the write, and return 32'hDEADBEEF for the read, with normal timing and counting.
REQ-028 Macro SIM_RAM_BOUNDS_CHECK_EN undefined: upper address bits SHALL be ignored (address aliases/wraps), err tied to 0.

Verification
REQ-029 LATENCY=1: write 0x7777F00D to addr 5, then 1-cycle readReq at addr 5 -> ramIn=0x7777F00D at accepting edge, ramValid high one cycle, readCount=1, writeCount=1.
REQ-030 LATENCY=3: readReq at A for addr 2 holding 0x12345678 -> busy high 3 cycles, ramIn=0x12345678 at A+2, ramValid high in cycle after A+2.
REQ-031 readReq+writeReq together, addr 9, ramOut=0xCAFEBABE -> ramIn=0xCAFEBABE, both counters +1.
REQ-032 LATENCY=4: second readReq while busy -> ignored, readCount unchanged, single ramValid pulse.
REQ-033 DEPTH_LOG2=10, addr 0x400 write 0x1: with SIM_RAM_BOUNDS_CHECK_EN -> err=1, addr 0 unchanged, read returns 0xDEADBEEF; without -> addr 0 reads 0x1, err=0.
REQ-034 LATENCY=4: reset asserted at A+1 after a write to addr 3 -> all outputs 0 immediately, no ramValid afterwards, later read of addr 3 returns written value.
